// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and fetch: FSM states,
// PC-select codes, default counter width and the redirect priority helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam int CNT_W_DEF = 16;

    // jr beats a taken branch, which beats a plain jump
    function automatic logic [1:0] redirect_sel(input logic jr, input logic br, input logic jmp);
        logic [1:0] sel;
        sel = PC_SEQ;
        if (jr)       sel = PC_JR;
        else if (br)  sel = PC_BR;
        else if (jmp) sel = PC_J;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: PC-select, stall/flush strobes, halt/resume, stall watchdog.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STALL_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_jr_EX,
    input  logic             br_taken_EX,
    input  logic             is_jump_EX,
    input  logic             load_use_EX,
    input  logic             mdu_busy,
    input  logic             halt_EX,
    input  logic             resume,
    output logic [1:0]       pc_src_EX,
    output logic             stall_EX,
    output logic             flush_EX,
    output logic             halted,
    output logic             stall_err,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TMR_W = $clog2(STALL_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             flush_q, flush_d;
    logic             halted_q, halted_d;

    logic             hazard;
    logic             redir_any;
    logic [1:0]       redir_sel;
    logic [1:0]       pc_src_c;
    logic             stall_c;

    assign hazard    = load_use_EX | mdu_busy;
    assign redir_any = is_jr_EX | br_taken_EX | is_jump_EX;
    assign redir_sel = redirect_sel(is_jr_EX, br_taken_EX, is_jump_EX);

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        pc_src_c = PC_SEQ;
        stall_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // An unresolved EX slot must not redirect, so hazards win.
                if (hazard) begin
                    stall_c = 1'b1;
                    tmr_d   = TMR_W'(1);
                    state_d = ST_STALL;
                end else if (halt_EX) begin
                    stall_c = 1'b1;
                    state_d = ST_HALT;
                end else if (redir_any) begin
                    pc_src_c = redir_sel;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_STALL: begin
                if (hazard) begin
                    stall_c = 1'b1;
                    // The entry cycle in RUN already counted as stall cycle 1.
                    if (tmr_q == TMR_W'(STALL_MAX - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                stall_c = 1'b1;
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        flush_d  = (state_d == ST_FLUSH);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            tmr_q    <= '0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    // Combinational strobes are masked so every output reads 0 while rst is held.
    assign pc_src_EX = rst ? PC_SEQ : pc_src_c;
    assign stall_EX  = stall_c & ~rst;
    assign flush_EX  = flush_q;
    assign halted    = halted_q;
    assign stall_err = err_q;

`ifdef PIPE_PERF_CNT_EN
    logic redirect_evt;
    logic stall_evt;

    assign redirect_evt = (state_q == ST_RUN) && (state_d == ST_FLUSH);
    assign stall_evt    = hazard && ((state_q == ST_RUN) || (state_q == ST_STALL));

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect_evt),
        .clr (1'b0),
        .q   (redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_evt),
        .clr (1'b0),
        .q   (stall_cnt)
    );
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: two instances (STALL_MAX 64 and 4) driven in lockstep
// by directed and random stimulus, checked against a cycle-level reference model.
module tb_pipe_seq_ctrl;

    localparam int CW = 16;
    localparam int R = 0, F = 1, S = 2, H = 3;

    logic clk, rst;
    logic is_jr, br, jmp, lu, mdu, hlt, res;

    logic [1:0]    pc  [2];
    logic          stl [2];
    logic          fl  [2];
    logic          hd  [2];
    logic          err [2];
    logic [CW-1:0] rc  [2];
    logic [CW-1:0] sc  [2];

    int total = 0;
    int bad   = 0;

    int ms [2];
    int mt [2];
    int me [2];
    int mrc[2];
    int msc[2];
    int mx [2] = '{64, 4};

    pipe_seq_ctrl #(.CNT_W(CW), .STALL_MAX(64)) dut (
        .clk(clk), .rst(rst), .is_jr_EX(is_jr), .br_taken_EX(br), .is_jump_EX(jmp),
        .load_use_EX(lu), .mdu_busy(mdu), .halt_EX(hlt), .resume(res),
        .pc_src_EX(pc[0]), .stall_EX(stl[0]), .flush_EX(fl[0]), .halted(hd[0]),
        .stall_err(err[0]), .redirect_cnt(rc[0]), .stall_cnt(sc[0])
    );

    pipe_seq_ctrl #(.CNT_W(CW), .STALL_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .is_jr_EX(is_jr), .br_taken_EX(br), .is_jump_EX(jmp),
        .load_use_EX(lu), .mdu_busy(mdu), .halt_EX(hlt), .resume(res),
        .pc_src_EX(pc[1]), .stall_EX(stl[1]), .flush_EX(fl[1]), .halted(hd[1]),
        .stall_err(err[1]), .redirect_cnt(rc[1]), .stall_cnt(sc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = R; mt[k] = 0; me[k] = 0; mrc[k] = 0; msc[k] = 0;
        end
    endtask

    // Expected outputs of instance k for the present state and inputs.
    task automatic check_all();
        logic [1:0] epc;
        logic est;
        int erc, esc;
        for (int k = 0; k < 2; k++) begin
            epc = 2'b00;
            est = 1'b0;
            if (!rst) begin
                case (ms[k])
                    R: begin
                        if (lu || mdu || hlt) est = 1'b1;
                        else if (is_jr)       epc = 2'b11;
                        else if (br)          epc = 2'b01;
                        else if (jmp)         epc = 2'b10;
                    end
                    S: est = lu | mdu;
                    H: est = 1'b1;
                    default: ;
                endcase
            end
`ifdef PIPE_PERF_CNT_EN
            erc = mrc[k];
            esc = msc[k];
`else
            erc = 0;
            esc = 0;
`endif
            chk($sformatf("pc_src[%0d]", k),    32'(pc[k]),  32'(epc));
            chk($sformatf("stall[%0d]", k),     32'(stl[k]), 32'(est));
            chk($sformatf("flush[%0d]", k),     32'(fl[k]),  32'(ms[k] == F));
            chk($sformatf("halted[%0d]", k),    32'(hd[k]),  32'(ms[k] == H));
            chk($sformatf("stall_err[%0d]", k), 32'(err[k]), 32'(me[k]));
            chk($sformatf("redir_cnt[%0d]", k), 32'(rc[k]),  32'(erc));
            chk($sformatf("stall_cnt[%0d]", k), 32'(sc[k]),  32'(esc));
        end
    endtask

    task automatic model_step();
        logic hz;
        hz = lu | mdu;
        for (int k = 0; k < 2; k++) begin
            case (ms[k])
                R: begin
                    if (hz) begin
                        ms[k] = S; mt[k] = 1;
                        if (msc[k] < 65535) msc[k]++;
                    end else if (hlt) begin
                        ms[k] = H;
                    end else if (is_jr || br || jmp) begin
                        ms[k] = F;
                        if (mrc[k] < 65535) mrc[k]++;
                    end
                end
                F: ms[k] = R;
                S: begin
                    if (hz) begin
                        if (msc[k] < 65535) msc[k]++;
                        if (mt[k] == mx[k] - 1) begin
                            me[k] = 1; ms[k] = H;
                        end else begin
                            mt[k]++;
                        end
                    end else begin
                        ms[k] = R;
                    end
                end
                default: if (res) ms[k] = R;
            endcase
        end
    endtask

    task automatic set_in(input logic a_lu, input logic a_mdu, input logic a_jr,
                          input logic a_br, input logic a_j, input logic a_h, input logic a_res);
        lu = a_lu; mdu = a_mdu; is_jr = a_jr; br = a_br; jmp = a_j; hlt = a_h; res = a_res;
    endtask

    // One clock: check mid-cycle, then advance the model with the sampled inputs.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single taken branch, then its flush cycle
        set_in(0, 0, 0, 1, 0, 0, 0); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // jr and branch together: jr wins
        set_in(0, 0, 1, 1, 0, 0, 0); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // load-use masks the branch until it clears
        set_in(1, 0, 0, 1, 0, 0, 0); cyc(); cyc();
        set_in(0, 0, 0, 1, 0, 0, 0); cyc(); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // five MDU cycles: fine for STALL_MAX=64, watchdog trips at 4
        repeat (5) begin set_in(0, 1, 0, 0, 0, 0, 0); cyc(); end
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
        set_in(0, 0, 0, 0, 0, 0, 1); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // halt, hold ten cycles with redirects ignored, resume
        set_in(0, 0, 0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 1, 1, 1, 0); repeat (10) cyc();
        set_in(0, 0, 0, 0, 0, 0, 1); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // async reset in the middle of HALT
        set_in(0, 0, 0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) == 0));
            cyc();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
